// File: rtl/test_pattern_gen.sv
// Streams table-driven and LFSR-driven MAC stimulus (a, w, p) with golden a*w+p, first beat one cycle after start.
// Valid/ready output; a stalled beat holds every pattern output and out_idx until accepted.
module test_pattern_gen #(
   parameter int          A_WIDTH      = 8,
   parameter int          W_WIDTH      = 8,
   parameter int          P_WIDTH      = 32,
   parameter int          NUM_PATTERNS = 16,
   parameter int          NUM_LFSR     = 64,
   parameter logic [31:0] LFSR_SEED    = 32'hACE12345,
   localparam int         IDX_WIDTH    = $clog2(NUM_PATTERNS + NUM_LFSR + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           mode,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [A_WIDTH-1:0]   out_tp_a,
   output logic [W_WIDTH-1:0]   out_tp_w,
   output logic [P_WIDTH-1:0]   out_tp_p,
   output logic [P_WIDTH-1:0]   out_expected_p,
   output logic [IDX_WIDTH-1:0] out_idx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [31:0]          LFSR_MASK = 32'h80200003;
   localparam logic [IDX_WIDTH-1:0] TBL_LAST  = IDX_WIDTH'(NUM_PATTERNS - 1);
   localparam logic [IDX_WIDTH-1:0] RND_LAST  = IDX_WIDTH'(NUM_LFSR - 1);
   localparam logic [IDX_WIDTH-1:0] MIX_LAST  = IDX_WIDTH'(NUM_PATTERNS + NUM_LFSR - 1);

   typedef enum logic [1:0] {S_IDLE, S_TABLE, S_RAND, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]          lfsr_q, lfsr_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [A_WIDTH-1:0]   a_q, a_d;
   logic [W_WIDTH-1:0]   w_q, w_d;
   logic [P_WIDTH-1:0]   p_q, p_d;
   logic [P_WIDTH-1:0]   e_q, e_d;

   logic                 xfer;
   logic [31:0]          lfsr_next;
   logic [IDX_WIDTH-1:0] rnd_last;

   logic [A_WIDTH-1:0]   tbl_a;
   logic [W_WIDTH-1:0]   tbl_w;
   logic [P_WIDTH-1:0]   tbl_p, tbl_e;

   logic signed [A_WIDTH-1:0]         rnd_a;
   logic signed [W_WIDTH-1:0]         rnd_w;
   logic signed [A_WIDTH+W_WIDTH-1:0] rnd_prod;
   logic signed [P_WIDTH-1:0]         rnd_p, rnd_e;

   assign xfer      = valid_q && out_ready;
   assign lfsr_next = lfsr_q[0] ? ({1'b0, lfsr_q[31:1]} ^ LFSR_MASK) : {1'b0, lfsr_q[31:1]};
   assign rnd_last  = (mode_q == 2'd2) ? MIX_LAST : RND_LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         idx_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
         w_q     <= '0;
         p_q     <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         lfsr_q  <= lfsr_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
         w_q     <= w_d;
         p_q     <= p_d;
         e_q     <= e_d;
      end
   end

   // Abort is checked before the transfer so it wins over a beat accepted in the same cycle.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      lfsr_d  = lfsr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode;
               idx_d  = '0;
               lfsr_d = LFSR_SEED;
               case (mode)
                  2'd1:    state_d = S_RAND;
                  2'd3:    state_d = S_DONE;
                  default: state_d = S_TABLE;
               endcase
            end
         end
         S_TABLE: begin
            if (abort) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (xfer) begin
               if (idx_q == TBL_LAST) begin
                  if (mode_q == 2'd2) begin
                     state_d = S_RAND;
                     idx_d   = idx_q + IDX_WIDTH'(1);
                  end else begin
                     state_d = S_DONE;
                     idx_d   = '0;
                  end
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         S_RAND: begin
            if (abort) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (xfer) begin
               lfsr_d = lfsr_next;
               if (idx_q == rnd_last) begin
                  state_d = S_DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pattern sources are looked up from the next index/LFSR so the registered outputs line up with out_idx.
   always_comb begin
      tbl_a = '0;
      tbl_w = '0;
      tbl_p = '0;
      tbl_e = '0;
      case (idx_d)
         IDX_WIDTH'(1): begin
            tbl_a = A_WIDTH'(5);    tbl_w = W_WIDTH'(10);
            tbl_p = P_WIDTH'(100);  tbl_e = P_WIDTH'(150);
         end
         IDX_WIDTH'(2): begin
            tbl_a = A_WIDTH'(-5);   tbl_w = W_WIDTH'(10);
            tbl_p = P_WIDTH'(100);  tbl_e = P_WIDTH'(50);
         end
         IDX_WIDTH'(3): begin
            tbl_a = A_WIDTH'(-5);   tbl_w = W_WIDTH'(-10);
            tbl_p = P_WIDTH'(100);  tbl_e = P_WIDTH'(150);
         end
         IDX_WIDTH'(4): begin
            tbl_a = A_WIDTH'(5);    tbl_w = W_WIDTH'(10);
            tbl_p = P_WIDTH'(-200); tbl_e = P_WIDTH'(-150);
         end
         IDX_WIDTH'(5): begin
            tbl_a = A_WIDTH'(120);  tbl_w = W_WIDTH'(0);
            tbl_p = P_WIDTH'(-50);  tbl_e = P_WIDTH'(-50);
         end
         default: ;
      endcase
   end

   always_comb begin
      rnd_a    = $signed(lfsr_d[A_WIDTH-1:0]);
      rnd_w    = $signed(lfsr_d[A_WIDTH +: W_WIDTH]);
      rnd_prod = rnd_a * rnd_w;
      rnd_p    = P_WIDTH'($signed(lfsr_d[31:16]));
      rnd_e    = P_WIDTH'(rnd_prod) + rnd_p;
   end

   always_comb begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      a_d     = '0;
      w_d     = '0;
      p_d     = '0;
      e_d     = '0;
      case (state_d)
         S_TABLE: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            a_d     = tbl_a;
            w_d     = tbl_w;
            p_d     = tbl_p;
            e_d     = tbl_e;
         end
         S_RAND: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            a_d     = rnd_a;
            w_d     = rnd_w;
            p_d     = rnd_p;
            e_d     = rnd_e;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   assign out_valid      = valid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign out_idx        = idx_q;
   assign out_tp_a       = a_q;
   assign out_tp_w       = w_q;
   assign out_tp_p       = p_q;
   assign out_expected_p = e_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: expected beats queued at start, popped on each accepted beat.
module tb_test_pattern_gen;

   localparam int          NP   = 16;
   localparam int          NL   = 64;
   localparam logic [31:0] SEED = 32'hACE12345;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_tp_a;
   logic [7:0]  out_tp_w;
   logic [31:0] out_tp_p;
   logic [31:0] out_expected_p;
   logic [6:0]  out_idx;
   logic        busy;
   logic        done;

   typedef struct {
      int idx;
      int a;
      int w;
      int p;
      int e;
   } beat_t;

   beat_t sb[$];
   int    total = 0;
   int    bad   = 0;

   test_pattern_gen dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .mode           (mode),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_tp_a       (out_tp_a),
      .out_tp_w       (out_tp_w),
      .out_tp_p       (out_tp_p),
      .out_expected_p (out_expected_p),
      .out_idx        (out_idx),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   function automatic beat_t tbl_beat(input int i);
      beat_t b;
      b = '{i, 0, 0, 0, 0};
      case (i)
         1: b = '{i,   5,  10,  100,  150};
         2: b = '{i,  -5,  10,  100,   50};
         3: b = '{i,  -5, -10,  100,  150};
         4: b = '{i,   5,  10, -200, -150};
         5: b = '{i, 120,   0,  -50,  -50};
         default: ;
      endcase
      return b;
   endfunction

   function automatic logic [31:0] m_step(input logic [31:0] s);
      logic [31:0] sh;
      sh = s >> 1;
      return s[0] ? (sh ^ 32'h80200003) : sh;
   endfunction

   function automatic beat_t rnd_beat(input int i, input logic [31:0] s);
      beat_t b;
      logic signed [7:0]  a8;
      logic signed [7:0]  w8;
      logic signed [15:0] p16;
      a8  = s[7:0];
      w8  = s[15:8];
      p16 = s[31:16];
      b.idx = i;
      b.a   = int'(a8);
      b.w   = int'(w8);
      b.p   = int'(p16);
      b.e   = b.a * b.w + b.p;
      return b;
   endfunction

   task automatic push_run(input int m);
      logic [31:0] s;
      int          k;
      s = SEED;
      k = 0;
      if (m == 0 || m == 2)
         for (int i = 0; i < NP; i++) begin
            sb.push_back(tbl_beat(k));
            k++;
         end
      if (m == 1 || m == 2)
         for (int i = 0; i < NL; i++) begin
            sb.push_back(rnd_beat(k, s));
            s = m_step(s);
            k++;
         end
   endtask

   // Mode is changed right after the start cycle so a run that follows it would show.
   task automatic do_start(input int m);
      @(negedge clk);
      start = 1'b1;
      mode  = 2'(m);
      @(posedge clk);
      #1;
      start = 1'b0;
      mode  = 2'(m + 1);
   endtask

   task automatic test_reset;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 7'd0 ||
          out_tp_a !== 8'd0 || out_tp_w !== 8'd0 || out_tp_p !== 32'd0 || out_expected_p !== 32'd0) begin
         bad++;
         $display("FAIL reset_state: got valid=%0b busy=%0b done=%0b idx=%0d, want all 0",
                  out_valid, busy, done, out_idx);
      end
      rst = 1'b0;
      do_start(1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_idx !== 7'd5) begin
         bad++;
         $display("FAIL midrun_before_reset: got valid=%0b idx=%0d, want valid=1 idx=5", out_valid, out_idx);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 7'd0 ||
          out_tp_a !== 8'd0 || out_tp_w !== 8'd0 || out_tp_p !== 32'd0 || out_expected_p !== 32'd0) begin
         bad++;
         $display("FAIL midrun_reset: got valid=%0b busy=%0b idx=%0d a=%0d, want all 0",
                  out_valid, busy, out_idx, out_tp_a);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      begin
         int vld_seen;
         vld_seen = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) vld_seen++;
         end
         total++;
         if (vld_seen !== 0) begin
            bad++;
            $display("FAIL no_beat_after_reset: got %0d valid cycles, want 0", vld_seen);
         end
      end
      out_ready = 1'b0;
      do_start(1);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_idx !== 7'd0 || $signed(out_tp_a) !== 8'sd69 || $signed(out_tp_w) !== 8'sd35 ||
          int'($signed(out_tp_p)) !== -21279 || int'($signed(out_expected_p)) !== -18864) begin
         bad++;
         $display("FAIL restart_seed: got idx=%0d (%0d,%0d,%0d,%0d), want idx=0 (69,35,-21279,-18864)", out_idx,
                  $signed(out_tp_a), $signed(out_tp_w), $signed(out_tp_p), $signed(out_expected_p));
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
   endtask

   task automatic test_table(input bit stall);
      beat_t exp;
      int beats, first_c, last_c, done_c, idx2_cyc, stall_left;
      beats = 0; first_c = -1; last_c = -1; done_c = -1; idx2_cyc = 0; stall_left = 3;
      sb.delete();
      push_run(0);
      do_start(0);
      for (int c = 0; c < 60 && done_c < 0; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (stall && out_valid && out_idx == 7'd2 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            total++;
            if ($signed(out_tp_a) !== -8'sd5 || $signed(out_tp_w) !== 8'sd10 ||
                int'($signed(out_tp_p)) !== 100 || int'($signed(out_expected_p)) !== 50) begin
               bad++;
               $display("FAIL table_hold: got (%0d,%0d,%0d,%0d), want (-5,10,100,50)", $signed(out_tp_a),
                        $signed(out_tp_w), $signed(out_tp_p), $signed(out_expected_p));
            end
         end
         if (out_valid && out_idx == 7'd2) idx2_cyc++;
         if (done) begin
            done_c = c;
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
               bad++;
               $display("FAIL table_done_flags: got valid=%0b busy=%0b, want 0 0", out_valid, busy);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL table_beat: got extra beat idx=%0d, want none", out_idx);
            end else begin
               exp = sb.pop_front();
               if (int'(out_idx) !== exp.idx || int'($signed(out_tp_a)) !== exp.a || int'($signed(out_tp_w)) !== exp.w ||
                   int'($signed(out_tp_p)) !== exp.p || int'($signed(out_expected_p)) !== exp.e) begin
                  bad++;
                  $display("FAIL table_beat: got idx=%0d (%0d,%0d,%0d,%0d), want idx=%0d (%0d,%0d,%0d,%0d)",
                           out_idx, $signed(out_tp_a), $signed(out_tp_w), $signed(out_tp_p), $signed(out_expected_p),
                           exp.idx, exp.a, exp.w, exp.p, exp.e);
               end
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            beats++;
         end
      end
      total++;
      if (beats !== NP || sb.size() !== 0) begin
         bad++;
         $display("FAIL table_count: got %0d beats (%0d left), want %0d", beats, sb.size(), NP);
      end
      total++;
      if (done_c !== last_c + 1) begin
         bad++;
         $display("FAIL table_done_timing: got done at %0d, want %0d", done_c, last_c + 1);
      end
      if (stall) begin
         total++;
         if (idx2_cyc !== 4) begin
            bad++;
            $display("FAIL table_stall_len: got idx2 for %0d cycles, want 4", idx2_cyc);
         end
      end else begin
         total++;
         if (last_c - first_c !== NP - 1) begin
            bad++;
            $display("FAIL table_b2b: got span %0d, want %0d", last_c - first_c, NP - 1);
         end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL table_idle: got done=%0b busy=%0b valid=%0b, want 0 0 0", done, busy, out_valid);
      end
   endtask

   task automatic test_rand;
      beat_t exp;
      int beats, first_c, last_c, done_c, a, w, p;
      beats = 0; first_c = -1; last_c = -1; done_c = -1;
      sb.delete();
      push_run(1);
      do_start(1);
      for (int c = 0; c < 120 && done_c < 0; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (done) done_c = c;
         if (out_valid && out_ready) begin
            a = int'($signed(out_tp_a));
            w = int'($signed(out_tp_w));
            p = int'($signed(out_tp_p));
            if (beats == 0) begin
               total++;
               if (a !== 69 || w !== 35 || p !== -21279 || int'($signed(out_expected_p)) !== -18864) begin
                  bad++;
                  $display("FAIL rand_first: got (%0d,%0d,%0d,%0d), want (69,35,-21279,-18864)", a, w, p,
                           $signed(out_expected_p));
               end
            end
            total++;
            if (int'($signed(out_expected_p)) !== a * w + p) begin
               bad++;
               $display("FAIL rand_mac: got %0d, want %0d", $signed(out_expected_p), a * w + p);
            end
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rand_beat: got extra beat idx=%0d, want none", out_idx);
            end else begin
               exp = sb.pop_front();
               if (int'(out_idx) !== exp.idx || a !== exp.a || w !== exp.w || p !== exp.p ||
                   int'($signed(out_expected_p)) !== exp.e) begin
                  bad++;
                  $display("FAIL rand_beat: got idx=%0d (%0d,%0d,%0d,%0d), want idx=%0d (%0d,%0d,%0d,%0d)",
                           out_idx, a, w, p, $signed(out_expected_p), exp.idx, exp.a, exp.w, exp.p, exp.e);
               end
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            beats++;
         end
      end
      total++;
      if (beats !== NL || done_c !== last_c + 1 || last_c - first_c !== NL - 1) begin
         bad++;
         $display("FAIL rand_run: got beats=%0d done_at=%0d span=%0d, want %0d %0d %0d", beats, done_c,
                  last_c - first_c, NL, last_c + 1, NL - 1);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      beat_t exp;
      int beats, first_c, last_c, done_c;
      beats = 0; first_c = -1; last_c = -1; done_c = -1;
      sb.delete();
      push_run(2);
      do_start(2);
      for (int c = 0; c < 150 && done_c < 0; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         start = out_valid && out_idx == 7'd7;
         if (start) mode = 2'd1;
         if (done) done_c = c;
         if (out_valid && out_ready) begin
            if (out_idx == 7'd16) begin
               total++;
               if ($signed(out_tp_a) !== 8'sd69 || $signed(out_tp_w) !== 8'sd35 ||
                   int'($signed(out_tp_p)) !== -21279 || int'($signed(out_expected_p)) !== -18864) begin
                  bad++;
                  $display("FAIL seam_beat: got (%0d,%0d,%0d,%0d), want (69,35,-21279,-18864)", $signed(out_tp_a),
                           $signed(out_tp_w), $signed(out_tp_p), $signed(out_expected_p));
               end
            end
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL b2b_beat: got extra beat idx=%0d, want none", out_idx);
            end else begin
               exp = sb.pop_front();
               if (int'(out_idx) !== exp.idx || int'($signed(out_tp_a)) !== exp.a || int'($signed(out_tp_w)) !== exp.w ||
                   int'($signed(out_tp_p)) !== exp.p || int'($signed(out_expected_p)) !== exp.e) begin
                  bad++;
                  $display("FAIL b2b_beat: got idx=%0d (%0d,%0d,%0d,%0d), want idx=%0d (%0d,%0d,%0d,%0d)",
                           out_idx, $signed(out_tp_a), $signed(out_tp_w), $signed(out_tp_p), $signed(out_expected_p),
                           exp.idx, exp.a, exp.w, exp.p, exp.e);
               end
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            beats++;
         end
      end
      start = 1'b0;
      total++;
      if (beats !== NP + NL || done_c !== last_c + 1 || last_c - first_c !== NP + NL - 1) begin
         bad++;
         $display("FAIL b2b_run: got beats=%0d done_at=%0d span=%0d, want %0d %0d %0d", beats, done_c,
                  last_c - first_c, NP + NL, last_c + 1, NP + NL - 1);
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int beats, done_seen;
      beats = 0; done_seen = 0;
      sb.delete();
      push_run(2);
      do_start(2);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (out_valid && out_idx == 7'd20) begin
            abort = 1'b1;
            break;
         end
         if (out_valid && out_ready) begin
            void'(sb.pop_front());
            beats++;
         end
      end
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: got valid=%0b busy=%0b done=%0b, want 0 0 0", out_valid, busy, done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done || out_valid) done_seen++;
      end
      total++;
      if (done_seen !== 0 || beats !== 20 || sb.size() !== NP + NL - 20) begin
         bad++;
         $display("FAIL abort_run: got late=%0d beats=%0d left=%0d, want 0 20 %0d", done_seen, beats, sb.size(),
                  NP + NL - 20);
      end
      sb.delete();
   endtask

   task automatic test_empty;
      do_start(3);
      @(negedge clk);
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_done: got done=%0b valid=%0b, want 1 0", done, out_valid);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL empty_idle: got done=%0b valid=%0b busy=%0b, want 0 0 0", done, out_valid, busy);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_table(1'b0);
      test_table(1'b1);
      test_rand();
      test_back_to_back();
      test_abort();
      test_empty();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
